ifu_fetch_axi: RTL and testbench
================================

# ifu_fetch_axi

Instruction-fetch bus master between the PC/fetch-register stage and instruction memory. Accepts one fetch address at a time over a valid/ready handshake and performs a single AXI4-Lite read. Presents the returned word with its PC to the fetch register over a second valid/ready handshake. Discards in-flight responses when a jump redirects the front end.

## Interface
- `DATA_LEN`, 32: data and address width.
- `NOP_INST`, 32'h00000013: instruction word driven on `inst` when no valid word is held.
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `pc_valid` input 1: fetch request present on `pc`.
- `pc` input DATA_LEN: fetch address.
- `pc_ready` output 1: request accepted this cycle; equals (state == IDLE).
- `flush` input 1: jump taken; kill the outstanding fetch.
- `inst_valid` output 1: `inst`, `inst_pc` and `inst_err` are valid.
- `inst` output DATA_LEN: fetched instruction.
- `inst_pc` output DATA_LEN: address of `inst`.
- `inst_err` output 1: bus or alignment error for this fetch.
- `inst_ready` input 1: downstream consumes the word.
- `araddr` output DATA_LEN: AXI read address.
- `arprot` output 3: constant 3'b100 (instruction, secure, unprivileged).
- `arvalid` output 1: AXI read address valid.
- `arready` input 1: AXI read address ready.
- `rdata` input DATA_LEN: AXI read data.
- `rresp` input 2: AXI read response.
- `rvalid` input 1: AXI read data valid.
- `rready` output 1: AXI read data ready; equals (state == R).

## Operation
- FSM states: IDLE, AR, R, HOLD. Reset state is IDLE.
- IDLE:
  - `pc_valid` latches `pc` into `araddr` and `inst_pc`, then goes to AR.
  - `flush` in IDLE has no effect. A request arriving with `flush` is accepted, because it is the jump target.
- AR:
  - `arvalid` = 1. `araddr` is held stable until `arready`, per AXI rules; a flush never drops `arvalid`.
  - `arready` goes to R.
  - `flush` in AR or on the `arready` cycle sets `drop`.
- R:
  - On `rvalid`: if `drop` (or `flush` this cycle), discard the data, clear `drop` and go to IDLE.
  - Otherwise latch `rdata` into `inst`, set `inst_err` = (`rresp` != 2'b00) and go to HOLD.
- HOLD:
  - `inst_valid` = 1; all outputs are held stable.
  - `inst_ready` goes to IDLE and clears `inst_valid`.
  - `flush` goes to IDLE and clears `inst_valid` without a handshake. `flush` wins over a simultaneous `inst_ready`.
- On error (`rresp` SLVERR/DECERR), `inst` is forced to `NOP_INST` and `inst_err` = 1.
- Only one transaction is ever outstanding. No AR is issued while in R or HOLD.

## Timing
- Reset values:
  - `arvalid`, `rready`, `inst_valid`, `inst_err` = 0.
  - `araddr`, `inst_pc` = 0.
  - `inst` = `NOP_INST`.
  - `pc_ready` = 1.
  - `drop` = 0.
- Reset asserted mid-transaction returns to IDLE immediately. The bus slave is reset together with this block.
- Minimum latency, with a zero-wait slave:
  - Accept at cycle t.
  - `arvalid` at t+1 (`arready` high).
  - `rready` at t+2 (`rvalid` high).
  - `inst_valid` at t+3.
  - Next `pc_ready` at t+4, after `inst_ready` at t+3.
- Each stall cycle on `arready` or `rvalid` adds one cycle.
- All outputs are registered except `pc_ready` and `rready`, which decode directly from the state.

## Configuration
- `IFU_MISALIGN_CHECK_EN` defined:
  - A request with `pc[1:0]` != 0 issues no AXI transaction.
  - IDLE goes directly to HOLD with `inst` = `NOP_INST`, `inst_pc` = `pc` and `inst_err` = 1, so `inst_valid` appears one cycle after accept.
- Not defined:
  - `araddr` = {`pc[DATA_LEN-1:2]`, 2'b00}. The fetch proceeds normally and `inst_pc` keeps the full `pc`.

## Test plan
- Zero-wait fetch:
  - Stimulus: `pc` = 32'h80000000, slave returns 32'h00100093 with OKAY.
  - Required: `inst_valid` 3 cycles after accept, `inst` = 32'h00100093, `inst_pc` = 32'h80000000, `inst_err` = 0.
- Backpressure:
  - Stimulus: `arready` low 3 cycles, `rvalid` low 2 cycles, `inst_ready` low 4 cycles.
  - Required: `araddr`, `arvalid` and the outputs stay stable throughout; the word is delivered exactly once.
- Flush during AR:
  - Stimulus: `flush` asserted while `arvalid` = 1.
  - Required: `arvalid` stays high until `arready`, the response is consumed with `rready` = 1, `inst_valid` never asserts, and the FSM returns to IDLE.
- Flush in HOLD with `inst_ready` in the same cycle:
  - Required: the word is dropped, `pc_ready` = 1 next cycle, and a new `pc` = 32'h80000100 is fetched correctly.
- Bus error:
  - Stimulus: `rresp` = 2'b10.
  - Required: `inst` = 32'h00000013, `inst_err` = 1.
- Misaligned `pc` = 32'h80000002:
  - With `IFU_MISALIGN_CHECK_EN`: no `arvalid`, `inst_err` = 1 one cycle after accept.
  - Without: `araddr` = 32'h80000000.
- Async reset asserted in R:
  - Required: all outputs return to their reset values in the same cycle.

Source files
------------

// File: rtl/ifu_fetch_axi.sv
// rtl/ifu_fetch_axi.sv - instruction-fetch AXI4-Lite read master (optional IFU_MISALIGN_CHECK_EN)
module ifu_fetch_axi #(
  parameter int                  DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0] NOP_INST = 32'h00000013
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pc_valid,
  input  logic [DATA_LEN-1:0] pc,
  output logic                pc_ready,
  input  logic                flush,
  output logic                inst_valid,
  output logic [DATA_LEN-1:0] inst,
  output logic [DATA_LEN-1:0] inst_pc,
  output logic                inst_err,
  input  logic                inst_ready,
  output logic [DATA_LEN-1:0] araddr,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_LEN-1:0] rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready
);

  typedef enum logic [1:0] {IDLE, AR, R, HOLD} state_t;

  state_t state, state_next;
  logic   drop, drop_next;
  logic   misalign;

`ifdef IFU_MISALIGN_CHECK_EN
  assign misalign = (pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign pc_ready = (state == IDLE);
  assign rready   = (state == R);
  assign arprot   = 3'b100;

  // State and drop-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
    end
  end

  // Next-state decode; a flush after AR issue is remembered so the late response is swallowed
  always_comb begin
    state_next = state;
    drop_next  = drop;
    case (state)
      IDLE: begin
        if (pc_valid) state_next = misalign ? HOLD : AR;
      end
      AR: begin
        if (flush)   drop_next  = 1'b1;
        if (arready) state_next = R;
      end
      R: begin
        if (rvalid) begin
          state_next = (drop || flush) ? IDLE : HOLD;
          drop_next  = 1'b0;
        end else if (flush) begin
          drop_next = 1'b1;
        end
      end
      HOLD: begin
        if (flush || inst_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered bus and fetch-register outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arvalid    <= 1'b0;
      inst_valid <= 1'b0;
      araddr     <= '0;
      inst_pc    <= '0;
      inst       <= NOP_INST;
      inst_err   <= 1'b0;
    end else begin
      arvalid    <= (state_next == AR);
      inst_valid <= (state_next == HOLD);
      case (state)
        IDLE: begin
          if (pc_valid) begin
            araddr  <= {pc[DATA_LEN-1:2], 2'b00};
            inst_pc <= pc;
            if (misalign) begin
              inst     <= NOP_INST;
              inst_err <= 1'b1;
            end
          end
        end
        R: begin
          if (rvalid && !(drop || flush)) begin
            if (rresp != 2'b00) begin
              inst     <= NOP_INST;
              inst_err <= 1'b1;
            end else begin
              inst     <= rdata;
              inst_err <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (flush || inst_ready) begin
            inst     <= NOP_INST;
            inst_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch_axi.sv
// tb/tb_ifu_fetch_axi.sv - directed vector bench for ifu_fetch_axi
module tb_ifu_fetch_axi;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_valid = 1'b0;
  logic [31:0] pc = '0;
  logic        pc_ready;
  logic        flush = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        inst_ready = 1'b0;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;

  ifu_fetch_axi dut (
    .clk(clk), .rst_n(rst_n), .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready),
    .flush(flush), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_err(inst_err), .inst_ready(inst_ready), .araddr(araddr), .arprot(arprot),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  // mode: 0 none, 1 flush first AR cycle, 2 flush with inst_ready in HOLD,
  //       3 flush on first R wait cycle, 4 flush with rvalid, 5 flush with accept
  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          ar_wait;
    int          r_wait;
    int          rdy_wait;
    int          mode;
    logic [31:0] exp_inst;
    logic        exp_err;
    logic        deliver;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int lat   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    lat++;
  endtask

  task automatic fetch(input vec_t v);
    logic [31:0] exp_addr;
    exp_addr = {v.pc[31:2], 2'b00};
    chk("idle_pc_ready", {31'b0, pc_ready}, 32'd1);
    pc_valid = 1'b1;
    pc       = v.pc;
    flush    = (v.mode == 5);
    step();
    lat = 1;
    pc_valid = 1'b0;
    flush    = 1'b0;
    // AR phase
    chk("ar_arvalid", {31'b0, arvalid}, 32'd1);
    chk("ar_araddr", araddr, exp_addr);
    chk("ar_arprot", {29'b0, arprot}, 32'd4);
    chk("ar_rready", {31'b0, rready}, 32'd0);
    for (int i = 0; i < v.ar_wait; i++) begin
      flush = (v.mode == 1 && i == 0);
      step();
      flush = 1'b0;
      chk("ar_hold_arvalid", {31'b0, arvalid}, 32'd1);
      chk("ar_hold_araddr", araddr, exp_addr);
    end
    arready = 1'b1;
    flush   = (v.mode == 1 && v.ar_wait == 0);
    step();
    arready = 1'b0;
    flush   = 1'b0;
    // R phase
    chk("r_rready", {31'b0, rready}, 32'd1);
    chk("r_arvalid", {31'b0, arvalid}, 32'd0);
    for (int i = 0; i < v.r_wait; i++) begin
      flush = (v.mode == 3 && i == 0);
      step();
      flush = 1'b0;
      chk("r_wait_rready", {31'b0, rready}, 32'd1);
    end
    rvalid = 1'b1;
    rdata  = v.rdata;
    rresp  = v.rresp;
    flush  = (v.mode == 4);
    step();
    rvalid = 1'b0;
    flush  = 1'b0;
    if (!v.deliver) begin
      chk("drop_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("drop_pc_ready", {31'b0, pc_ready}, 32'd1);
    end else begin
      chk("hold_latency", lat, 3 + v.ar_wait + v.r_wait);
      chk("hold_inst_valid", {31'b0, inst_valid}, 32'd1);
      chk("hold_inst", inst, v.exp_inst);
      chk("hold_inst_pc", inst_pc, v.pc);
      chk("hold_inst_err", {31'b0, inst_err}, {31'b0, v.exp_err});
      for (int i = 0; i < v.rdy_wait; i++) begin
        step();
        chk("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("stall_inst", inst, v.exp_inst);
        chk("stall_pc_ready", {31'b0, pc_ready}, 32'd0);
      end
      inst_ready = 1'b1;
      flush      = (v.mode == 2);
      step();
      inst_ready = 1'b0;
      flush      = 1'b0;
      chk("done_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("done_pc_ready", {31'b0, pc_ready}, 32'd1);
      chk("done_inst_nop", inst, NOP);
    end
    // one extra idle cycle: nothing must reappear
    step();
    chk("post_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("post_arvalid", {31'b0, arvalid}, 32'd0);
  endtask

  vec_t vecs [9];

  initial begin
    vecs[0] = '{32'h80000000, 32'h00100093, 2'b00, 0, 0, 0, 0, 32'h00100093, 1'b0, 1'b1};
    vecs[1] = '{32'h80000004, 32'h00200113, 2'b00, 3, 2, 4, 0, 32'h00200113, 1'b0, 1'b1};
    vecs[2] = '{32'h80000008, 32'hdeadbeef, 2'b00, 2, 0, 0, 1, 32'h0,        1'b0, 1'b0};
    vecs[3] = '{32'h8000000c, 32'h00300193, 2'b00, 0, 0, 0, 2, 32'h00300193, 1'b0, 1'b1};
    vecs[4] = '{32'h80000100, 32'h00400213, 2'b00, 0, 1, 0, 0, 32'h00400213, 1'b0, 1'b1};
    vecs[5] = '{32'h80000200, 32'h12345678, 2'b10, 1, 0, 1, 0, NOP,          1'b1, 1'b1};
    vecs[6] = '{32'h80000204, 32'h87654321, 2'b11, 0, 1, 0, 0, NOP,          1'b1, 1'b1};
    vecs[7] = '{32'h80000208, 32'hcafef00d, 2'b00, 0, 2, 0, 3, 32'h0,        1'b0, 1'b0};
    vecs[8] = '{32'h8000020c, 32'h0badf00d, 2'b00, 1, 0, 0, 4, 32'h0,        1'b0, 1'b0};

    // reset state
    #12;
    chk("rst_pc_ready", {31'b0, pc_ready}, 32'd1);
    chk("rst_arvalid", {31'b0, arvalid}, 32'd0);
    chk("rst_rready", {31'b0, rready}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_inst_err", {31'b0, inst_err}, 32'd0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 9; k++) fetch(vecs[k]);

    // flush together with a new request: the jump target is still fetched
    fetch('{32'h80000300, 32'h00500293, 2'b00, 0, 0, 0, 5, 32'h00500293, 1'b0, 1'b1});

    // misaligned pc
    pc_valid = 1'b1;
    pc       = 32'h80000002;
    step();
    pc_valid = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    chk("mis_arvalid", {31'b0, arvalid}, 32'd0);
    chk("mis_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("mis_inst_err", {31'b0, inst_err}, 32'd1);
    chk("mis_inst", inst, NOP);
    chk("mis_inst_pc", inst_pc, 32'h80000002);
`else
    chk("mis_arvalid", {31'b0, arvalid}, 32'd1);
    chk("mis_araddr", araddr, 32'h80000000);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'h00600313;
    rresp   = 2'b00;
    step();
    rvalid  = 1'b0;
    chk("mis_inst", inst, 32'h00600313);
    chk("mis_inst_pc", inst_pc, 32'h80000002);
    chk("mis_inst_err", {31'b0, inst_err}, 32'd0);
`endif
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("mis_done_pc_ready", {31'b0, pc_ready}, 32'd1);

    // async reset while in R
    pc_valid = 1'b1;
    pc       = 32'h80000400;
    step();
    pc_valid = 1'b0;
    arready  = 1'b1;
    step();
    arready  = 1'b0;
    chk("pre_rst_rready", {31'b0, rready}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rready", {31'b0, rready}, 32'd0);
    chk("arst_pc_ready", {31'b0, pc_ready}, 32'd1);
    chk("arst_arvalid", {31'b0, arvalid}, 32'd0);
    chk("arst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("arst_inst", inst, NOP);
    chk("arst_araddr", araddr, 32'h0);
    chk("arst_inst_pc", inst_pc, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // fetch after reset works normally
    fetch(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
